multicycle_ctrl: RTL

Sequential successor to the combinational control unit. Sequences each MIPS instruction through fetch, decode, execute, memory, writeback, multiply/divide wait and exception states, and generates the per-cycle write enables.
- Memory wait states and multiply/divide latencies are parameters.
- Datapath mux selects stay in the combinational decoder; this block drives only enables, handshakes and exception signalling.

---
 rtl/multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control sequencer: drives write enables, memory strobes, mul/div handshake and exceptions.
// Optional macro CTRL_PERF_EN adds the instret/cycles performance counters.
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT   = 2,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        rs_eq_rt,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        hilo_we,
    output logic        md_start,
    output logic        exception,
    output logic        eret_out,
    output logic [4:0]  cause,
    output logic [2:0]  state,
    output logic        busy,
    output logic [31:0] instret,
    output logic [31:0] cycles
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_MDWAIT = 3'd5;
    localparam logic [2:0] S_EXC    = 3'd6;

    localparam logic [3:0] C_ALU = 4'd0,  C_LOAD = 4'd1,  C_STORE = 4'd2,  C_BRANCH = 4'd3;
    localparam logic [3:0] C_LINK = 4'd4, C_MTHILO = 4'd5, C_MTC0 = 4'd6, C_MUL = 4'd7;
    localparam logic [3:0] C_MULTU = 4'd8, C_DIV = 4'd9, C_TEQ = 4'd10, C_SYSCALL = 4'd11;
    localparam logic [3:0] C_BREAK = 4'd12, C_ERET = 4'd13, C_RSVD = 4'd14;

    localparam logic [4:0] CAUSE_SYS  = 5'b01000;
    localparam logic [4:0] CAUSE_BRK  = 5'b01001;
    localparam logic [4:0] CAUSE_RI   = 5'b01010;
    localparam logic [4:0] CAUSE_TRAP = 5'b01101;

    localparam logic [5:0] MEM_LAST = 6'(MEM_WAIT);
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [4:0] cause_q, cause_d;
    logic [3:0] cls;
    logic [5:0] opc, fn;
    logic [4:0] rs_f, rt_f;
    logic       retire;
    logic       pc_we_c, ir_we_c, rf_we_c, re_c, we_c, hilo_c, md_c, exc_c, eret_c;
    logic       unused_inst;

    assign opc = inst[31:26];
    assign rs_f = inst[25:21];
    assign rt_f = inst[20:16];
    assign fn  = inst[5:0];
    assign unused_inst = ^inst[15:6];

    always_comb begin
        cls = C_RSVD;
        case (opc)
            6'h00: begin
                case (fn)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: cls = C_ALU;
                    6'h08:        cls = C_BRANCH;
                    6'h09:        cls = C_LINK;
                    6'h0C:        cls = C_SYSCALL;
                    6'h0D:        cls = C_BREAK;
                    6'h11, 6'h13: cls = C_MTHILO;
                    6'h19:        cls = C_MULTU;
                    6'h1A, 6'h1B: cls = C_DIV;
                    6'h34:        cls = C_TEQ;
                    default:      cls = C_RSVD;
                endcase
            end
            6'h01: cls = (rt_f == 5'd1) ? C_BRANCH : C_RSVD;
            6'h02, 6'h04, 6'h05: cls = C_BRANCH;
            6'h03: cls = C_LINK;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: cls = C_ALU;
            6'h10: begin
                if (rs_f == 5'h00)                     cls = C_ALU;
                else if (rs_f == 5'h04)                cls = C_MTC0;
                else if (rs_f == 5'h10 && fn == 6'h18) cls = C_ERET;
                else                                   cls = C_RSVD;
            end
            6'h1C: cls = (fn == 6'h02) ? C_MUL : C_RSVD;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: cls = C_LOAD;
            6'h28, 6'h29, 6'h2B: cls = C_STORE;
            default: cls = C_RSVD;
        endcase
    end

    // FETCH and MEM count up to MEM_LAST so the post-reset counter value (0) starts a full fetch;
    // MDWAIT counts down from the loaded latency.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        retire  = 1'b0;
        pc_we_c = 1'b0; ir_we_c = 1'b0; rf_we_c = 1'b0; re_c = 1'b0; we_c = 1'b0;
        hilo_c  = 1'b0; md_c = 1'b0; exc_c = 1'b0; eret_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (cnt_q == MEM_LAST) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DECODE: begin
                cnt_d   = '0;
                state_d = S_EXEC;
                case (cls)
                    C_SYSCALL: begin state_d = S_EXC; cause_d = CAUSE_SYS; end
                    C_BREAK:   begin state_d = S_EXC; cause_d = CAUSE_BRK; end
                    C_RSVD:    begin state_d = S_EXC; cause_d = CAUSE_RI;  end
                    C_TEQ: if (rs_eq_rt) begin state_d = S_EXC; cause_d = CAUSE_TRAP; end
                    C_ERET: begin
                        eret_c  = 1'b1;
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_MUL, C_MULTU: begin md_c = 1'b1; state_d = S_MDWAIT; cnt_d = MUL_LOAD; end
                    C_DIV:          begin md_c = 1'b1; state_d = S_MDWAIT; cnt_d = DIV_LOAD; end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                cnt_d   = '0;
                state_d = S_WB;
                case (cls)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH: begin pc_we_c = 1'b1; retire = 1'b1; state_d = S_FETCH; end
                    C_LINK:   pc_we_c = 1'b1;
                    default:  state_d = S_WB;
                endcase
            end
            S_MEM: begin
                re_c = (cls == C_LOAD);
                if (cnt_q == MEM_LAST) begin
                    cnt_d = '0;
                    if (cls == C_STORE) begin
                        we_c    = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_WB: begin
                case (cls)
                    C_MTHILO:     hilo_c  = 1'b1;
                    C_MTC0, C_TEQ: rf_we_c = 1'b0;
                    default:      rf_we_c = 1'b1;
                endcase
                retire  = 1'b1;
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            S_MDWAIT: begin
                if (cnt_q == '0) begin
                    rf_we_c = (cls == C_MUL);
                    hilo_c  = (cls != C_MUL);
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            S_EXC: begin
                exc_c   = 1'b1;
                pc_we_c = 1'b1;
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Gating with rst keeps every strobe low while reset is held, whatever MEM_WAIT is.
    assign pc_we     = pc_we_c & ~rst;
    assign ir_we     = ir_we_c & ~rst;
    assign rf_we     = rf_we_c & ~rst;
    assign dmem_re   = re_c    & ~rst;
    assign dmem_we   = we_c    & ~rst;
    assign hilo_we   = hilo_c  & ~rst;
    assign md_start  = md_c    & ~rst;
    assign exception = exc_c   & ~rst;
    assign eret_out  = eret_c  & ~rst;
    assign cause     = cause_q;
    assign state     = state_q;
    assign busy      = (state_q != S_FETCH);

`ifdef CTRL_PERF_EN
    logic [31:0] instret_q, cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
    assign cycles  = cycles_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instret = '0;
    assign cycles  = '0;
`endif

endmodule
